mips_cpu_ifetch: RTL and testbench
==================================

# mips_cpu_ifetch

Instruction fetch stage between `mips_cpu_pc` and decode. It takes the current PC and issues single-word reads on the Avalon-style instruction bus, waiting out wait-states. It holds the returned word in an instruction register and presents it to decode with a valid/ready handshake. It pulses `pc_advance` to the PC stage once per completed fetch, supports flush on redirect, and stops fetching when the PC stage reports inactive.

## Interface
- `RESET_VECTOR`, default 32'hBFC00000: value driven on `mem_address` while in IDLE.
- `CNT_W`, default 16: width of the retired-fetch counter.

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `pc`  in  32  current PC from the PC stage.
- `active`  in  1  PC stage running flag; 0 means halt.
- `flush`  in  1  discard held or in-flight instruction (branch/jump redirect).
- `mem_address`  out  32  byte address, word aligned.
- `mem_read`  out  1  read request.
- `mem_waitrequest`  in  1  bus stall; the transfer completes on a cycle with `mem_read` high and `mem_waitrequest` low.
- `mem_readdata`  in  32  read data, valid in the completing cycle.
- `instr`  out  32  fetched instruction.
- `instr_pc`  out  32  address `instr` was fetched from.
- `instr_valid`  out  1  `instr` / `instr_pc` valid.
- `instr_ready`  in  1  decode accepts.
- `pc_advance`  out  1  one-cycle strobe: PC stage may step.
- `fetch_err`  out  1  sticky: misaligned PC detected.
- `fetch_count`  out  CNT_W  instructions accepted by decode, wraps.

## Operation
- **States:** IDLE, FETCH, HOLD, HALT.
- **IDLE:**
  - `mem_read`=0, `mem_address`=RESET_VECTOR.
  - Next cycle: FETCH if `active`=1 and `pc[1:0]`=0.
  - If `active`=1 and `pc[1:0]`≠0: HALT and set `fetch_err`.
  - If `active`=0: HALT.
- **FETCH:**
  - `mem_read`=1, `mem_address`=`pc` latched on entry (`pc_q`).
  - `pc_q` and `mem_read` stay stable while `mem_waitrequest`=1, even if `pc` changes. The bus protocol forbids dropping a request mid-wait.
  - On completion: latch `mem_readdata` into `instr` and `pc_q` into `instr_pc`, pulse `pc_advance`, then HOLD.
- **HOLD:**
  - `instr_valid`=1; `instr` and `instr_pc` are stable until accepted.
  - On `instr_valid`&`instr_ready`: increment `fetch_count`, then IDLE (next PC re-sampled).
- **HALT:**
  - Terminal until `rst`; all strobes 0.
  - `instr_valid` still completes its current handshake first: HOLD with `active`=0 finishes accept, then IDLE, then HALT.
- **Flush:**
  - In HOLD: `instr_valid` clears next cycle, no count, go to IDLE. Flush wins over a simultaneous accept.
  - In FETCH: sets `drop_q`. The transfer still completes, data is discarded, `pc_advance` is not pulsed, and the state goes to IDLE. `drop_q` clears on completion.
  - In IDLE/HALT: no effect.
- `fetch_count` is modulo 2^CNT_W.

## Timing
- **Reset values:**
  - `mem_read`=0, `mem_address`=RESET_VECTOR, `instr`=0, `instr_pc`=0.
  - `instr_valid`=0, `pc_advance`=0, `fetch_err`=0, `fetch_count`=0.
  - State IDLE, `drop_q`=0.
- **Latency, zero wait-states:**
  - Cycle N IDLE, N+1 `mem_read`, N+2 `instr_valid`.
  - `pc_advance` is asserted in cycle N+1, the completion cycle.
- **Wait-states:** each cycle of `mem_waitrequest`=1 adds one cycle.
- **Throughput:** one instruction per 3 cycles minimum (IDLE, FETCH, HOLD) with `instr_ready` tied high.
- **Registered outputs:** all outputs are registered except `mem_read` and `pc_advance`, which decode from state/inputs combinationally.
- **Reset mid-transfer:** `rst` during FETCH drops `mem_read` next cycle. The bus sees the request abandoned; this is acceptable only at reset.

## Configuration
- `MIPS_IFETCH_BYTESWAP_EN`
  - Defined: `instr` = {rd[7:0], rd[15:8], rd[23:16], rd[31:24]} of `mem_readdata` (big-endian image on little-endian bus).
  - Undefined: `instr` = `mem_readdata` unchanged.

## Test plan
- **Reset then `active`=1, `pc`=32'hBFC00000, no wait-states, `mem_readdata`=32'h24020005, `instr_ready`=1:** read in cycle 2 at 32'hBFC00000, `pc_advance` in cycle 2, `instr_valid` in cycle 3 with `instr`=32'h24020005 (byte-swapped 32'h05000224 when macro defined), `fetch_count`=1.
- **`mem_waitrequest` high 4 cycles, `pc` changed to 32'h100 mid-wait:** `mem_address` stays 32'hBFC00000, `mem_read` stays 1 for 5 cycles, `instr_pc`=32'hBFC00000.
- **`instr_ready`=0 for 6 cycles in HOLD:** `instr` stable, no new `mem_read`, `fetch_count` unchanged; increments once on accept.
- **`flush` during wait-state, then in HOLD with simultaneous `instr_ready`:** data dropped, no `pc_advance`, no count; next fetch uses new `pc`.
- **`pc`=32'hBFC00002 with `active`=1:** no read, `fetch_err`=1, HALT. Separately, `active`=0 after accept: goes to HALT, `mem_read` never reasserted.

Source files
------------

// File: rtl/mips_cpu_ifetch_if.sv
// mips_cpu_ifetch_if
//   Bundles the instruction-bus and decode-handshake signals of the fetch stage.
//   The master side is the fetch stage. The slave side is the memory and decode
//   pair, or a testbench standing in for them.
//
//   Instruction bus (Avalon-style, single-word reads):
//     mem_address     byte address, word aligned
//     mem_read        read request
//     mem_waitrequest stall. A transfer completes on a cycle with
//                     mem_read=1 and mem_waitrequest=0.
//     mem_readdata    read data, valid in the completing cycle
//
//   Decode handshake:
//     instr           fetched instruction
//     instr_pc        address instr was fetched from
//     instr_valid     instr and instr_pc are valid
//     instr_ready     decode accepts
//
//   Handshake rule: a word transfers on every cycle where instr_valid and
//   instr_ready are both high. Once instr_valid rises, instr and instr_pc hold
//   until that cycle. The one exception is a flush, which may withdraw
//   instr_valid. instr_valid never depends on instr_ready.
interface mips_cpu_ifetch_if;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output mem_address, mem_read, instr, instr_pc, instr_valid,
    input  mem_waitrequest, mem_readdata, instr_ready
  );

  modport slave (
    input  mem_address, mem_read, instr, instr_pc, instr_valid,
    output mem_waitrequest, mem_readdata, instr_ready
  );
endinterface

// File: rtl/mips_cpu_ifetch.sv
// mips_cpu_ifetch
//   Instruction fetch stage between mips_cpu_pc and decode. It runs one fetch at
//   a time through the cycle IDLE -> FETCH -> HOLD. The stage stops in HALT when
//   the PC stage goes inactive or the PC is misaligned.
//
//   Parameters
//     RESET_VECTOR  value driven on mem_address while the stage is not fetching
//     CNT_W         width of fetch_count
//
//   Build option
//     MIPS_IFETCH_BYTESWAP_EN  when defined, each fetched word is byte-reversed
//                              (big-endian image on a little-endian bus)
//
//   Ports
//     clk, rst     clock; synchronous active-high reset
//     pc           current PC from the PC stage
//     active       PC stage running flag; 0 means halt
//     flush        discard the held or in-flight instruction (redirect)
//     bus          instruction bus and decode handshake (master modport)
//     pc_advance   one-cycle strobe on a kept fetch completion
//     fetch_err    sticky flag for a misaligned PC
//     fetch_count  instructions accepted by decode, modulo 2^CNT_W
//     state_dbg    current FSM state (IDLE=0, FETCH=1, HOLD=2, HALT=3)
module mips_cpu_ifetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter int          CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc,
  input  logic              active,
  input  logic              flush,
  mips_cpu_ifetch_if.master bus,
  output logic              pc_advance,
  output logic              fetch_err,
  output logic [CNT_W-1:0]  fetch_count,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q;
  logic [31:0]      mem_address_q;
  logic [31:0]      instr_q;
  logic [31:0]      instr_pc_q;
  logic             instr_valid_q;
  logic             drop_q;
  logic             fetch_err_q;
  logic [CNT_W-1:0] fetch_count_q;

  logic             done;     // bus transfer completes this cycle
  logic             accept;   // decode takes the held word this cycle
  logic             bad_pc;   // misaligned PC seen while in IDLE
  logic             discard;  // completing data belongs to a flushed fetch
  logic [31:0]      fetch_word;

`ifdef MIPS_IFETCH_BYTESWAP_EN
  assign fetch_word = {bus.mem_readdata[7:0],   bus.mem_readdata[15:8],
                       bus.mem_readdata[23:16], bus.mem_readdata[31:24]};
`else
  assign fetch_word = bus.mem_readdata;
`endif

  // A flush that lands on the completion cycle itself also discards the data.
  assign discard = drop_q | flush;

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    accept  = 1'b0;
    bad_pc  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!active) begin
          state_d = S_HALT;
        end else if (pc[1:0] != 2'b00) begin
          state_d = S_HALT;
          bad_pc  = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // The request cannot be withdrawn mid-wait, so a flush only marks the
        // fetch for discard. The transfer still completes.
        if (!bus.mem_waitrequest) begin
          done    = 1'b1;
          state_d = discard ? S_IDLE : S_HOLD;
        end
      end
      S_HOLD: begin
        // Flush takes priority over a simultaneous accept.
        if (flush) begin
          state_d = S_IDLE;
        end else if (bus.instr_ready) begin
          accept  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  assign bus.mem_read = (state_q == S_FETCH);
  assign pc_advance   = done & ~discard;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= 32'd0;
      mem_address_q <= RESET_VECTOR;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      instr_valid_q <= 1'b0;
      drop_q        <= 1'b0;
      fetch_err_q   <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && state_d == S_FETCH) begin
        pc_q          <= pc;
        mem_address_q <= pc;
      end else if (done) begin
        mem_address_q <= RESET_VECTOR;
      end
      drop_q <= (state_q == S_FETCH) & bus.mem_waitrequest & discard;
      if (pc_advance) begin
        instr_q    <= fetch_word;
        instr_pc_q <= pc_q;
      end
      instr_valid_q <= (state_d == S_HOLD);
      if (bad_pc) begin
        fetch_err_q <= 1'b1;
      end
      if (accept) begin
        fetch_count_q <= fetch_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.mem_address = mem_address_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign fetch_err       = fetch_err_q;
  assign fetch_count     = fetch_count_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_mips_cpu_ifetch.sv
// tb_mips_cpu_ifetch
//   Directed bench for mips_cpu_ifetch. The bench drives inputs 1 ns after each
//   rising edge and checks outputs 2 ns after it. A negedge monitor checks each
//   decode accept against a queue of expected fetch addresses. The counter is
//   built 4 bits wide so that wrap-around can be reached in a short run.
module tb_mips_cpu_ifetch;
  localparam int          CNT_W = 4;
  localparam logic [31:0] RV    = 32'hBFC00000;
  localparam logic [31:0] ST_IDLE = 32'd0, ST_FETCH = 32'd1, ST_HOLD = 32'd2, ST_HALT = 32'd3;

  logic             clk;
  logic             rst;
  logic [31:0]      pc;
  logic             active;
  logic             flush;
  logic             pc_advance;
  logic             fetch_err;
  logic [CNT_W-1:0] fetch_count;
  logic [1:0]       state_dbg;

  mips_cpu_ifetch_if bus_if ();

  mips_cpu_ifetch #(.RESET_VECTOR(RV), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .active      (active),
    .flush       (flush),
    .bus         (bus_if),
    .pc_advance  (pc_advance),
    .fetch_err   (fetch_err),
    .fetch_count (fetch_count),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] exp_instr(input logic [31:0] d);
`ifdef MIPS_IFETCH_BYTESWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // scoreboard: every accepted word must come from the next expected address
  always @(negedge clk) begin
    if (!rst && bus_if.instr_valid && bus_if.instr_ready && !flush) begin
      if (exp_q.size() == 0) chk("accept_unexpected", bus_if.instr_pc, 32'hFFFFFFFF);
      else chk("accept_pc", bus_if.instr_pc, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    rst = 1'b1; active = 1'b1; pc = RV; flush = 1'b0;
    bus_if.mem_waitrequest = 1'b0;
    bus_if.mem_readdata    = 32'h24020005;
    bus_if.instr_ready     = 1'b1;
    repeat (2) next_cycle();
    settle();
    // reset values
    chk("rst_mem_read",    32'(bus_if.mem_read),    32'd0);
    chk("rst_mem_address", bus_if.mem_address,      RV);
    chk("rst_instr",       bus_if.instr,            32'd0);
    chk("rst_instr_pc",    bus_if.instr_pc,         32'd0);
    chk("rst_instr_valid", 32'(bus_if.instr_valid), 32'd0);
    chk("rst_pc_advance",  32'(pc_advance),         32'd0);
    chk("rst_fetch_err",   32'(fetch_err),          32'd0);
    chk("rst_fetch_count", 32'(fetch_count),        32'd0);
    chk("rst_state",       32'(state_dbg),          ST_IDLE);
    rst = 1'b0;

    // basic fetch with zero wait-states
    chk("t1_c1_mem_read", 32'(bus_if.mem_read), 32'd0);
    exp_q.push_back(RV);
    next_cycle(); settle();
    chk("t1_c2_mem_read",   32'(bus_if.mem_read), 32'd1);
    chk("t1_c2_address",    bus_if.mem_address,   RV);
    chk("t1_c2_pc_advance", 32'(pc_advance),      32'd1);
    next_cycle(); settle();
    chk("t1_c3_valid",      32'(bus_if.instr_valid), 32'd1);
    chk("t1_c3_instr",      bus_if.instr,            exp_instr(32'h24020005));
    chk("t1_c3_instr_pc",   bus_if.instr_pc,         RV);
    chk("t1_c3_pc_advance", 32'(pc_advance),         32'd0);
    bus_if.mem_waitrequest = 1'b1;
    next_cycle(); settle();
    chk("t1_c4_count", 32'(fetch_count),        32'd1);
    chk("t1_c4_valid", 32'(bus_if.instr_valid), 32'd0);
    chk("t1_c4_state", 32'(state_dbg),          ST_IDLE);

    // four wait-states with the PC changing mid-wait
    exp_q.push_back(RV);
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      if (k == 1) pc = 32'h100;
      if (k == 4) begin
        bus_if.mem_waitrequest = 1'b0;
        bus_if.mem_readdata    = 32'h8C430004;
      end
      settle();
      chk("t2_address",    bus_if.mem_address,   RV);
      chk("t2_mem_read",   32'(bus_if.mem_read), 32'd1);
      chk("t2_pc_advance", 32'(pc_advance),      (k == 4) ? 32'd1 : 32'd0);
    end
    next_cycle();
    bus_if.instr_ready  = 1'b0;
    bus_if.mem_readdata = 32'hDEADBEEF;
    settle();
    chk("t2_valid",    32'(bus_if.instr_valid), 32'd1);
    chk("t2_instr_pc", bus_if.instr_pc,         RV);
    chk("t2_instr",    bus_if.instr,            exp_instr(32'h8C430004));

    // decode stalls for six cycles in HOLD
    for (int k = 0; k < 5; k++) begin
      next_cycle(); settle();
      chk("t3_instr",    bus_if.instr,            exp_instr(32'h8C430004));
      chk("t3_valid",    32'(bus_if.instr_valid), 32'd1);
      chk("t3_mem_read", 32'(bus_if.mem_read),    32'd0);
      chk("t3_count",    32'(fetch_count),        32'd1);
    end
    next_cycle();
    bus_if.instr_ready = 1'b1;
    settle();
    chk("t3_acc_count", 32'(fetch_count), 32'd1);
    bus_if.mem_waitrequest = 1'b1;
    next_cycle(); settle();
    chk("t3_post_count", 32'(fetch_count), 32'd2);
    chk("t3_post_state", 32'(state_dbg),   ST_IDLE);

    // flush during a wait-state
    next_cycle();
    flush = 1'b1;
    settle();
    chk("t4_address",    bus_if.mem_address,   32'h100);
    chk("t4_mem_read",   32'(bus_if.mem_read), 32'd1);
    chk("t4_pc_advance", 32'(pc_advance),      32'd0);
    next_cycle();
    flush = 1'b0;
    bus_if.mem_waitrequest = 1'b0;
    settle();
    chk("t4_done_mem_read",   32'(bus_if.mem_read), 32'd1);
    chk("t4_done_pc_advance", 32'(pc_advance),      32'd0);
    next_cycle();
    pc = 32'h200;
    bus_if.mem_readdata = 32'h00851020;
    settle();
    chk("t4_drop_state", 32'(state_dbg),          ST_IDLE);
    chk("t4_drop_valid", 32'(bus_if.instr_valid), 32'd0);
    chk("t4_drop_count", 32'(fetch_count),        32'd2);
    chk("t4_drop_instr", bus_if.instr,            exp_instr(32'h8C430004));
    next_cycle(); settle();
    chk("t4_new_address",    bus_if.mem_address, 32'h200);
    chk("t4_new_pc_advance", 32'(pc_advance),    32'd1);
    next_cycle();
    flush = 1'b1;
    settle();
    chk("t4_hold_valid",   32'(bus_if.instr_valid), 32'd1);
    chk("t4_hold_instr_pc", bus_if.instr_pc,        32'h200);
    next_cycle();
    flush = 1'b0;
    settle();
    chk("t4_fl_valid", 32'(bus_if.instr_valid), 32'd0);
    chk("t4_fl_count", 32'(fetch_count),        32'd2);
    chk("t4_fl_state", 32'(state_dbg),          ST_IDLE);

    // back-to-back fetches at three cycles each; counter wraps 15 -> 0
    for (int i = 0; i < 14; i++) begin
      a  = 32'h400 + 32'(4 * i);
      pc = a;
      bus_if.mem_readdata = 32'h1000 + 32'(i);
      exp_q.push_back(a);
      next_cycle(); settle();
      chk("t5_address",    bus_if.mem_address, a);
      chk("t5_pc_advance", 32'(pc_advance),    32'd1);
      next_cycle(); settle();
      chk("t5_valid", 32'(bus_if.instr_valid), 32'd1);
      chk("t5_instr", bus_if.instr,            exp_instr(32'h1000 + 32'(i)));
      next_cycle(); settle();
      chk("t5_idle", 32'(state_dbg), ST_IDLE);
    end
    chk("t5_wrap_count", 32'(fetch_count), 32'd0);

    // active drops while a word is held: accept, IDLE, then HALT
    pc = 32'h300;
    exp_q.push_back(32'h300);
    next_cycle(); settle();
    chk("t6_pc_advance", 32'(pc_advance), 32'd1);
    next_cycle();
    active = 1'b0;
    settle();
    chk("t6_valid", 32'(bus_if.instr_valid), 32'd1);
    next_cycle(); settle();
    chk("t6_idle_state", 32'(state_dbg),        ST_IDLE);
    chk("t6_idle_count", 32'(fetch_count),      32'd1);
    chk("t6_idle_read",  32'(bus_if.mem_read),  32'd0);
    next_cycle();
    active = 1'b1;
    settle();
    chk("t6_halt_state", 32'(state_dbg), ST_HALT);
    for (int k = 0; k < 4; k++) begin
      next_cycle(); settle();
      chk("t6_halt_read",   32'(bus_if.mem_read), 32'd0);
      chk("t6_halt_adv",    32'(pc_advance),      32'd0);
      chk("t6_halt_stays",  32'(state_dbg),       ST_HALT);
    end
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    // misaligned PC: no read, sticky error, HALT
    rst = 1'b1;
    pc  = 32'hBFC00002;
    next_cycle(); next_cycle(); settle();
    chk("t7_rst_err",   32'(fetch_err),   32'd0);
    chk("t7_rst_count", 32'(fetch_count), 32'd0);
    chk("t7_rst_state", 32'(state_dbg),   ST_IDLE);
    rst = 1'b0;
    chk("t7_c1_read", 32'(bus_if.mem_read), 32'd0);
    for (int k = 0; k < 4; k++) begin
      next_cycle(); settle();
      chk("t7_err",   32'(fetch_err),        32'd1);
      chk("t7_state", 32'(state_dbg),        ST_HALT);
      chk("t7_read",  32'(bus_if.mem_read),  32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
